// File: rtl/axi_type_pkg.sv
// AXI4 field widths, burst/response encodings and a wrap-length helper shared by the memory
// subordinate and its burst address generator.
package axi_type_pkg;

   localparam int unsigned LenWidth   = 8;
   localparam int unsigned SizeWidth  = 3;
   localparam int unsigned BurstWidth = 2;
   localparam int unsigned RespWidth  = 2;

   typedef enum logic [BurstWidth-1:0] {
      BurstFixed = 2'b00,
      BurstIncr  = 2'b01,
      BurstWrap  = 2'b10
   } burst_t;

   typedef enum logic [RespWidth-1:0] {
      RespOkay   = 2'b00,
      RespExokay = 2'b01,
      RespSlverr = 2'b10,
      RespDecerr = 2'b11
   } resp_t;

   localparam logic [BurstWidth-1:0] BurstRsvd = 2'b11;

   function automatic logic wrap_len_ok(input logic [LenWidth-1:0] len);
      return len inside {8'd1, 8'd3, 8'd7, 8'd15};
   endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address and burst legality for one AXI4 address channel.
// Illegal WRAP lengths and the reserved burst type advance as INCR and raise err_o.
module axi_burst_addr_gen
   import axi_type_pkg::*;
#(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned StrbWidth = 4
) (
   input  logic [AddrWidth-1:0]  addr_i,
   input  logic [LenWidth-1:0]   len_i,
   input  logic [SizeWidth-1:0]  size_i,
   input  logic [BurstWidth-1:0] burst_i,
   output logic [AddrWidth-1:0]  next_addr_o,
   output logic                  err_o
);

   localparam int unsigned MaxSize = $clog2(StrbWidth);

   logic                 size_err;
   logic                 wrap_ok;
   logic                 burst_err;
   logic [SizeWidth-1:0] size_eff;
   logic [AddrWidth-1:0] step;
   logic [AddrWidth-1:0] wrap_bytes;
   logic [AddrWidth-1:0] boundary;
   logic [AddrWidth-1:0] incr_addr;

   always_comb begin
      size_err   = size_i > SizeWidth'(MaxSize);
      size_eff   = size_err ? SizeWidth'(MaxSize) : size_i;
      wrap_ok    = wrap_len_ok(len_i);
      burst_err  = (burst_i == BurstRsvd) || ((burst_i == BurstWrap) && !wrap_ok);
      step       = AddrWidth'(1) << size_eff;
      wrap_bytes = (AddrWidth'(len_i) + AddrWidth'(1)) << size_eff;
      boundary   = addr_i & ~(wrap_bytes - AddrWidth'(1));
      incr_addr  = addr_i + step;
      next_addr_o = incr_addr;
      if (burst_i == BurstFixed) begin
         next_addr_o = addr_i;
      end else if ((burst_i == BurstWrap) && wrap_ok &&
                   (incr_addr >= boundary + wrap_bytes)) begin
         next_addr_o = incr_addr - wrap_bytes;
      end
      err_o = size_err || burst_err;
   end

endmodule

// File: rtl/axi_mem_slv.sv
// AXI4 subordinate backed by an on-chip word memory; one outstanding burst per direction.
// Define AXI_MEM_SLV_RANGE_CHECK_EN to flag SLVERR on addresses beyond the memory.
module axi_mem_slv
   import axi_type_pkg::*;
#(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned IdWidth   = 4,
   parameter int unsigned MemWords  = 256,
   localparam int unsigned StrbWidth = DataWidth / 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [IdWidth-1:0]    aw_id_i,
   input  logic [AddrWidth-1:0]  aw_addr_i,
   input  logic [LenWidth-1:0]   aw_len_i,
   input  logic [SizeWidth-1:0]  aw_size_i,
   input  logic [BurstWidth-1:0] aw_burst_i,
   input  logic                  aw_valid_i,
   output logic                  aw_ready_o,
   input  logic [DataWidth-1:0]  w_data_i,
   input  logic [StrbWidth-1:0]  w_strb_i,
   input  logic                  w_last_i,
   input  logic                  w_valid_i,
   output logic                  w_ready_o,
   output logic [IdWidth-1:0]    b_id_o,
   output logic [RespWidth-1:0]  b_resp_o,
   output logic                  b_valid_o,
   input  logic                  b_ready_i,
   input  logic [IdWidth-1:0]    ar_id_i,
   input  logic [AddrWidth-1:0]  ar_addr_i,
   input  logic [LenWidth-1:0]   ar_len_i,
   input  logic [SizeWidth-1:0]  ar_size_i,
   input  logic [BurstWidth-1:0] ar_burst_i,
   input  logic                  ar_valid_i,
   output logic                  ar_ready_o,
   output logic [IdWidth-1:0]    r_id_o,
   output logic [DataWidth-1:0]  r_data_o,
   output logic [RespWidth-1:0]  r_resp_o,
   output logic                  r_last_o,
   output logic                  r_valid_o,
   input  logic                  r_ready_i
);

   localparam int unsigned ByteBits = $clog2(StrbWidth);
   localparam int unsigned IdxBits  = $clog2(MemWords);

   typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
   typedef enum logic {RIdle, RData} r_state_e;

   logic [DataWidth-1:0] mem_q [MemWords];

   // Write path state
   w_state_e              w_state_q, w_state_d;
   logic                  aw_ready_q, w_ready_q, b_valid_q;
   logic [IdWidth-1:0]    w_id_q, w_id_d;
   logic [AddrWidth-1:0]  w_addr_q, w_addr_d;
   logic [LenWidth-1:0]   w_len_q, w_len_d, w_cnt_q, w_cnt_d;
   logic [SizeWidth-1:0]  w_size_q, w_size_d;
   logic [BurstWidth-1:0] w_burst_q, w_burst_d;
   logic                  w_err_q, w_err_d;
   logic [AddrWidth-1:0]  w_next_addr;
   logic                  w_gen_err, w_oor, mem_we;
   logic                  aw_hs, w_hs, b_hs;

   // Read path state
   r_state_e              r_state_q, r_state_d;
   logic                  ar_ready_q, r_valid_q;
   logic [IdWidth-1:0]    r_id_q, r_id_d;
   logic [AddrWidth-1:0]  r_addr_q, r_addr_d;
   logic [LenWidth-1:0]   r_len_q, r_len_d, r_cnt_q, r_cnt_d;
   logic [SizeWidth-1:0]  r_size_q, r_size_d;
   logic [BurstWidth-1:0] r_burst_q, r_burst_d;
   logic [DataWidth-1:0]  r_data_q, r_data_d;
   logic                  r_last_q, r_last_d;
   logic                  r_oor_q, r_oor_d;
   logic [AddrWidth-1:0]  r_next_addr, r_fetch_addr;
   logic                  r_gen_err, r_oor, r_fetch;
   logic                  ar_hs, r_hs;

   assign aw_hs = aw_valid_i && aw_ready_q;
   assign w_hs  = w_valid_i && w_ready_q;
   assign b_hs  = b_valid_q && b_ready_i;
   assign ar_hs = ar_valid_i && ar_ready_q;
   assign r_hs  = r_valid_q && r_ready_i;

   axi_burst_addr_gen #(
      .AddrWidth (AddrWidth),
      .StrbWidth (StrbWidth)
   ) u_w_addr_gen (
      .addr_i      (w_addr_q),
      .len_i       (w_len_q),
      .size_i      (w_size_q),
      .burst_i     (w_burst_q),
      .next_addr_o (w_next_addr),
      .err_o       (w_gen_err)
   );

   axi_burst_addr_gen #(
      .AddrWidth (AddrWidth),
      .StrbWidth (StrbWidth)
   ) u_r_addr_gen (
      .addr_i      (r_addr_q),
      .len_i       (r_len_q),
      .size_i      (r_size_q),
      .burst_i     (r_burst_q),
      .next_addr_o (r_next_addr),
      .err_o       (r_gen_err)
   );

`ifdef AXI_MEM_SLV_RANGE_CHECK_EN
   assign w_oor = w_addr_q >= AddrWidth'(MemWords * StrbWidth);
   assign r_oor = r_fetch_addr >= AddrWidth'(MemWords * StrbWidth);
`else
   assign w_oor = 1'b0;
   assign r_oor = 1'b0;
`endif

   // ---------------- Write FSM ----------------
   always_comb begin
      w_state_d = w_state_q;
      w_id_d    = w_id_q;
      w_addr_d  = w_addr_q;
      w_len_d   = w_len_q;
      w_size_d  = w_size_q;
      w_burst_d = w_burst_q;
      w_cnt_d   = w_cnt_q;
      w_err_d   = w_err_q;
      mem_we    = 1'b0;
      unique case (w_state_q)
         WIdle: begin
            if (aw_hs) begin
               w_id_d    = aw_id_i;
               w_addr_d  = aw_addr_i;
               w_len_d   = aw_len_i;
               w_size_d  = aw_size_i;
               w_burst_d = aw_burst_i;
               w_cnt_d   = '0;
               w_err_d   = 1'b0;
               w_state_d = WData;
            end
         end
         WData: begin
            if (w_hs) begin
               mem_we   = !w_oor;
               w_addr_d = w_next_addr;
               w_cnt_d  = w_cnt_q + 1'b1;
               // Length always comes from aw_len; w_last only cross-checks it.
               if ((w_last_i != (w_cnt_q == w_len_q)) || w_oor) begin
                  w_err_d = 1'b1;
               end
               if (w_cnt_q == w_len_q) begin
                  w_state_d = WResp;
               end
            end
         end
         WResp: begin
            if (b_hs) begin
               w_state_d = WIdle;
            end
         end
         default: w_state_d = WIdle;
      endcase
   end

   // ---------------- Read FSM ----------------
   always_comb begin
      r_state_d    = r_state_q;
      r_id_d       = r_id_q;
      r_addr_d     = r_addr_q;
      r_len_d      = r_len_q;
      r_size_d     = r_size_q;
      r_burst_d    = r_burst_q;
      r_cnt_d      = r_cnt_q;
      r_last_d     = r_last_q;
      r_data_d     = r_data_q;
      r_oor_d      = r_oor_q;
      r_fetch      = 1'b0;
      r_fetch_addr = r_next_addr;
      unique case (r_state_q)
         RIdle: begin
            if (ar_hs) begin
               r_id_d       = ar_id_i;
               r_addr_d     = ar_addr_i;
               r_len_d      = ar_len_i;
               r_size_d     = ar_size_i;
               r_burst_d    = ar_burst_i;
               r_cnt_d      = '0;
               r_last_d     = (ar_len_i == '0);
               r_fetch      = 1'b1;
               r_fetch_addr = ar_addr_i;
               r_state_d    = RData;
            end
         end
         RData: begin
            if (r_hs) begin
               if (r_last_q) begin
                  r_last_d  = 1'b0;
                  r_state_d = RIdle;
               end else begin
                  r_cnt_d  = r_cnt_q + 1'b1;
                  r_last_d = ((r_cnt_q + 1'b1) == r_len_q);
                  r_addr_d = r_next_addr;
                  r_fetch  = 1'b1;
               end
            end
         end
         default: r_state_d = RIdle;
      endcase
      // Next beat is fetched as the current one is accepted, so no bubbles.
      if (r_fetch) begin
         r_data_d = r_oor ? '0 : mem_q[r_fetch_addr[IdxBits+ByteBits-1:ByteBits]];
         r_oor_d  = r_oor;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         w_state_q  <= WIdle;
         aw_ready_q <= 1'b0;
         w_ready_q  <= 1'b0;
         b_valid_q  <= 1'b0;
         w_id_q     <= '0;
         w_addr_q   <= '0;
         w_len_q    <= '0;
         w_size_q   <= '0;
         w_burst_q  <= '0;
         w_cnt_q    <= '0;
         w_err_q    <= 1'b0;
         r_state_q  <= RIdle;
         ar_ready_q <= 1'b0;
         r_valid_q  <= 1'b0;
         r_id_q     <= '0;
         r_addr_q   <= '0;
         r_len_q    <= '0;
         r_size_q   <= '0;
         r_burst_q  <= '0;
         r_cnt_q    <= '0;
         r_data_q   <= '0;
         r_last_q   <= 1'b0;
         r_oor_q    <= 1'b0;
      end else begin
         w_state_q  <= w_state_d;
         aw_ready_q <= (w_state_d == WIdle);
         w_ready_q  <= (w_state_d == WData);
         b_valid_q  <= (w_state_d == WResp);
         w_id_q     <= w_id_d;
         w_addr_q   <= w_addr_d;
         w_len_q    <= w_len_d;
         w_size_q   <= w_size_d;
         w_burst_q  <= w_burst_d;
         w_cnt_q    <= w_cnt_d;
         w_err_q    <= w_err_d;
         r_state_q  <= r_state_d;
         ar_ready_q <= (r_state_d == RIdle);
         r_valid_q  <= (r_state_d == RData);
         r_id_q     <= r_id_d;
         r_addr_q   <= r_addr_d;
         r_len_q    <= r_len_d;
         r_size_q   <= r_size_d;
         r_burst_q  <= r_burst_d;
         r_cnt_q    <= r_cnt_d;
         r_data_q   <= r_data_d;
         r_last_q   <= r_last_d;
         r_oor_q    <= r_oor_d;
      end
   end

   // Contents are not reset; a same-edge read samples the pre-write word.
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int b = 0; b < StrbWidth; b++) begin
            if (w_strb_i[b]) begin
               mem_q[w_addr_q[IdxBits+ByteBits-1:ByteBits]][8*b +: 8] <= w_data_i[8*b +: 8];
            end
         end
      end
   end

   assign aw_ready_o = aw_ready_q;
   assign w_ready_o  = w_ready_q;
   assign b_valid_o  = b_valid_q;
   assign b_id_o     = w_id_q;
   assign b_resp_o   = (w_err_q || w_gen_err) ? RespSlverr : RespOkay;
   assign ar_ready_o = ar_ready_q;
   assign r_valid_o  = r_valid_q;
   assign r_id_o     = r_id_q;
   assign r_data_o   = r_data_q;
   assign r_last_o   = r_last_q;
   assign r_resp_o   = (r_gen_err || r_oor_q) ? RespSlverr : RespOkay;

endmodule

// File: tb/tb_axi_mem_slv.sv
// Randomized self-checking bench for axi_mem_slv against a byte-level memory model.
// Expectations follow AXI_MEM_SLV_RANGE_CHECK_EN when it is defined.
module tb_axi_mem_slv;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  aw_id, ar_id, b_id, r_id;
   logic [31:0] aw_addr, ar_addr, w_data, r_data;
   logic [7:0]  aw_len, ar_len;
   logic [2:0]  aw_size, ar_size;
   logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
   logic [3:0]  w_strb;
   logic        aw_valid, aw_ready, w_last, w_valid, w_ready, b_valid, b_ready;
   logic        ar_valid, ar_ready, r_last, r_valid, r_ready;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] mdl [256];
   logic [31:0] wdata [16];
   logic [3:0]  wstrb [16];

   always #5 clk = ~clk;

   axi_mem_slv u_dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .aw_id_i    (aw_id),
      .aw_addr_i  (aw_addr),
      .aw_len_i   (aw_len),
      .aw_size_i  (aw_size),
      .aw_burst_i (aw_burst),
      .aw_valid_i (aw_valid),
      .aw_ready_o (aw_ready),
      .w_data_i   (w_data),
      .w_strb_i   (w_strb),
      .w_last_i   (w_last),
      .w_valid_i  (w_valid),
      .w_ready_o  (w_ready),
      .b_id_o     (b_id),
      .b_resp_o   (b_resp),
      .b_valid_o  (b_valid),
      .b_ready_i  (b_ready),
      .ar_id_i    (ar_id),
      .ar_addr_i  (ar_addr),
      .ar_len_i   (ar_len),
      .ar_size_i  (ar_size),
      .ar_burst_i (ar_burst),
      .ar_valid_i (ar_valid),
      .ar_ready_o (ar_ready),
      .r_id_o     (r_id),
      .r_data_o   (r_data),
      .r_resp_o   (r_resp),
      .r_last_o   (r_last),
      .r_valid_o  (r_valid),
      .r_ready_i  (r_ready)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit wrap_legal(input int unsigned len);
      return (len == 1) || (len == 3) || (len == 7) || (len == 15);
   endfunction

   function automatic bit burst_bad(input int unsigned burst, input int unsigned len,
                                    input int unsigned size);
      return (burst == 3) || (burst == 2 && !wrap_legal(len)) || (size > 2);
   endfunction

   // Address of beat i, from the burst rules directly (window-relative modulo for WRAP).
   function automatic logic [31:0] beat_addr(input logic [31:0] addr, input int unsigned len,
                                             input int unsigned size, input int unsigned burst,
                                             input int unsigned i);
      int unsigned bytes, total, base;
      bytes = 32'd1 << ((size > 2) ? 2 : size);
      if (burst == 0) return addr;
      if (burst == 2 && wrap_legal(len)) begin
         total = (len + 1) * bytes;
         base  = (addr / total) * total;
         return base + ((addr - base + i * bytes) % total);
      end
      return addr + i * bytes;
   endfunction

   function automatic bit out_of_range(input logic [31:0] a);
`ifdef AXI_MEM_SLV_RANGE_CHECK_EN
      return a >= 32'd1024;
`else
      return a[31:0] != a[31:0] + 32'd0 ? 1'b1 : 1'b0;
`endif
   endfunction

   task automatic mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [7:0] idx;
      idx = a[9:2];
      for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
   endtask

   task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int unsigned len,
                           input int unsigned size, input int unsigned burst, input int early,
                           input int b_stall);
      int          n;
      bit          err;
      logic [31:0] a;
      err = burst_bad(burst, len, size) || (early >= 0);
      @(negedge clk);
      aw_id = id; aw_addr = addr; aw_len = 8'(len); aw_size = 3'(size); aw_burst = 2'(burst);
      aw_valid = 1'b1;
      n = 0;
      while (!aw_ready && n < 50) begin @(negedge clk); n++; end
      check_eq("aw_ready", aw_ready, 1);
      @(posedge clk); #1;
      aw_valid = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         w_data = wdata[i]; w_strb = wstrb[i];
         w_last = (early >= 0) ? (i == early) : (i == int'(len));
         w_valid = 1'b1;
         @(negedge clk);
         if (i == 0) check_eq("w_ready_first", w_ready, 1);
         n = 0;
         while (!w_ready && n < 50) begin @(negedge clk); n++; end
         @(posedge clk); #1;
         a = beat_addr(addr, len, size, burst, i);
         if (out_of_range(a)) err = 1'b1;
         else mdl_write(a, wdata[i], wstrb[i]);
      end
      w_valid = 1'b0; w_last = 1'b0;
      @(negedge clk);
      check_eq("b_valid", b_valid, 1);
      for (int k = 0; k < b_stall; k++) begin
         @(negedge clk);
         check_eq("b_valid_held", b_valid, 1);
         check_eq("aw_ready_during_b", aw_ready, 0);
      end
      check_eq("b_resp", b_resp, err ? 2'b10 : 2'b00);
      check_eq("b_id", b_id, id);
      b_ready = 1'b1;
      @(posedge clk); #1;
      b_ready = 1'b0;
      @(negedge clk);
      check_eq("b_valid_drop", b_valid, 0);
      check_eq("aw_ready_after_b", aw_ready, 1);
   endtask

   task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int unsigned len,
                          input int unsigned size, input int unsigned burst, input int stall_beat,
                          input int stall_cyc);
      int          n;
      logic [31:0] a, exp_d;
      logic [1:0]  exp_r;
      r_ready = 1'b1;
      @(negedge clk);
      ar_id = id; ar_addr = addr; ar_len = 8'(len); ar_size = 3'(size); ar_burst = 2'(burst);
      ar_valid = 1'b1;
      n = 0;
      while (!ar_ready && n < 50) begin @(negedge clk); n++; end
      check_eq("ar_ready", ar_ready, 1);
      @(posedge clk); #1;
      ar_valid = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         a     = beat_addr(addr, len, size, burst, i);
         exp_d = out_of_range(a) ? 32'h0 : mdl[a[9:2]];
         exp_r = (burst_bad(burst, len, size) || out_of_range(a)) ? 2'b10 : 2'b00;
         @(negedge clk);
         if (i == stall_beat) begin
            r_ready = 1'b0;
            for (int k = 0; k < stall_cyc; k++) begin
               check_eq("r_valid_stall", r_valid, 1);
               check_eq("r_data_stall", r_data, exp_d);
               check_eq("r_last_stall", r_last, i == int'(len));
               @(negedge clk);
            end
            r_ready = 1'b1;
         end
         check_eq("r_valid", r_valid, 1);
         check_eq("r_data", r_data, exp_d);
         check_eq("r_last", r_last, i == int'(len));
         check_eq("r_resp", r_resp, exp_r);
         check_eq("r_id", r_id, id);
         @(posedge clk); #1;
      end
      @(negedge clk);
      check_eq("r_valid_drop", r_valid, 0);
      check_eq("ar_ready_after_r", ar_ready, 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned len, size, burst;
      logic [31:0] addr;
      rst_n = 1'b0;
      aw_id = '0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0; aw_valid = 1'b0;
      w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0; b_ready = 1'b0;
      ar_id = '0; ar_addr = '0; ar_len = '0; ar_size = '0; ar_burst = '0; ar_valid = 1'b0;
      r_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_aw_ready", aw_ready, 0);
      check_eq("rst_ar_ready", ar_ready, 0);
      check_eq("rst_w_ready", w_ready, 0);
      check_eq("rst_b_valid", {b_valid, b_resp, b_id}, 0);
      check_eq("rst_r_out", {r_valid, r_last, r_resp, r_id, r_data}, 0);
      rst_n = 1'b1;
      #1;
      check_eq("aw_ready_pre_edge", aw_ready, 0);
      @(negedge clk);
      check_eq("aw_ready_post_rst", aw_ready, 1);
      check_eq("ar_ready_post_rst", ar_ready, 1);

      // Fill the whole memory so later reads are fully defined.
      for (int w = 0; w < 16; w++) begin
         for (int i = 0; i < 16; i++) begin wdata[i] = $urandom; wstrb[i] = 4'hF; end
         do_write(4'(w), 32'(w * 64), 15, 2, 1, -1, 0);
      end

      // INCR write/read back
      for (int i = 0; i < 4; i++) begin wdata[i] = 32'hA0 + 32'(i); wstrb[i] = 4'hF; end
      do_write(4'h3, 32'h10, 3, 2, 1, -1, 0);
      do_read(4'h5, 32'h10, 3, 2, 1, -1, 0);
      // WRAP read over preloaded words
      do_read(4'h6, 32'h38, 3, 2, 2, -1, 0);
      // FIXED write keeps last beat
      for (int i = 0; i < 3; i++) begin wdata[i] = 32'(i + 1); wstrb[i] = 4'hF; end
      do_write(4'h7, 32'h20, 2, 2, 0, -1, 0);
      do_read(4'h8, 32'h20, 0, 2, 1, -1, 0);
      // Byte strobes
      wdata[0] = 32'h12345678; wstrb[0] = 4'hF;
      do_write(4'h9, 32'h40, 0, 2, 1, -1, 0);
      wdata[0] = 32'hFFFFFFFF; wstrb[0] = 4'h5;
      do_write(4'h9, 32'h40, 0, 2, 1, -1, 0);
      do_read(4'hA, 32'h40, 0, 2, 1, -1, 0);
      // Backpressure on R and B
      do_read(4'hB, 32'h80, 3, 2, 1, 2, 3);
      for (int i = 0; i < 2; i++) begin wdata[i] = $urandom; wstrb[i] = 4'hF; end
      do_write(4'hC, 32'h90, 1, 2, 1, -1, 4);
      // Errors: early w_last, reserved burst, out-of-range address
      for (int i = 0; i < 4; i++) begin wdata[i] = $urandom; wstrb[i] = 4'hF; end
      do_write(4'hD, 32'hA0, 3, 2, 1, 1, 0);
      do_write(4'hE, 32'hC0, 3, 2, 3, -1, 0);
      do_read(4'hE, 32'hC0, 3, 2, 3, -1, 0);
      wdata[0] = 32'hDEADBEEF; wstrb[0] = 4'hF;
      do_write(4'h1, 32'h400, 0, 2, 1, -1, 0);
      do_read(4'h2, 32'h0, 0, 2, 1, -1, 0);
      do_read(4'h2, 32'h400, 0, 2, 1, -1, 0);

      // Randomized traffic
      for (int t = 0; t < 40; t++) begin
         burst = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
         size  = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
         if (burst == 2 && $urandom_range(0, 4) != 0) len = (32'd2 << $urandom_range(0, 3)) - 1;
         else len = $urandom_range(0, 15);
         addr = 32'($urandom_range(0, 1023));
         addr = addr & ~((32'd1 << ((size > 2) ? 2 : size)) - 1);
         if ($urandom_range(0, 1) == 1) begin
            for (int i = 0; i < 16; i++) begin wdata[i] = $urandom; wstrb[i] = 4'($urandom); end
            do_write(4'($urandom), addr, len, size, burst,
                     (len > 0 && $urandom_range(0, 5) == 0) ? int'($urandom_range(0, len - 1)) : -1,
                     $urandom_range(0, 3));
         end else begin
            do_read(4'($urandom), addr, len, size, burst, int'($urandom_range(0, len + 2)),
                    $urandom_range(1, 3));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
